axi_b_arbiter: RTL

AXI_B_ARBITER -- requirements
Module: axi_b_arbiter

---
 rtl/axi_b_arbiter_if.sv | 26 ++
 rtl/axi_b_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/axi_b_arbiter_if.sv
// B-channel bundle between the AXI response sources, the arbiter and master 1.
// The slave modport is the arbiter's view; the master modport is the
// environment's view (sources, master 1 and the AW-side tracker).
interface axi_b_arbiter_if;
   logic [5:0]  BVALID_S;
   logic [47:0] BID_S;
   logic [11:0] BRESP_S;
   logic [5:0]  BREADY_S;
   logic [5:0]  AW_DONE;
   logic        BREADY_M;
   logic        BVALID_M;
   logic [3:0]  BID_M;
   logic [1:0]  BRESP_M;
   logic        BUSY;
   logic        RESP_ERR;

   modport slave (
      input  BVALID_S, BID_S, BRESP_S, AW_DONE, BREADY_M,
      output BREADY_S, BVALID_M, BID_M, BRESP_M, BUSY, RESP_ERR
   );

   modport master (
      output BVALID_S, BID_S, BRESP_S, AW_DONE, BREADY_M,
      input  BREADY_S, BVALID_M, BID_M, BRESP_M, BUSY, RESP_ERR
   );
endinterface

// File: rtl/axi_b_arbiter.sv
// Round-robin B-response arbiter for master 1 across five slaves plus the
// default slave. Tracks outstanding writes per source and flags responses
// that arrive with nothing outstanding.
module axi_b_arbiter (
   input  logic             ACLK,
   input  logic             ARESETn,
   axi_b_arbiter_if.slave   bus
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t      state, state_next;
   logic [2:0]  g, g_next;
   logic [2:0]  p, p_next;
   logic [2:0]  cnt [6];
   logic        resp_err;

   logic [5:0]  eligible;
   logic [5:0]  eligible_hs;
   logic [3:0]  bid_arr [6];
   logic [1:0]  resp_arr [6];
   logic [5:0]  dec_vec;
   logic [5:0]  ready_vec;
   logic        handshake;
   logic        idle_found, hs_found;
   logic [2:0]  idle_win, hs_win;

   // Index increment modulo 6 (indices 0..5 only).
   function automatic logic [2:0] wrap_inc(input logic [2:0] x);
      return (x >= 3'd5) ? 3'd0 : x + 3'd1;
   endfunction

   // First set bit of elig scanning from ptr upward, wrapping at 6.
   // Returns {found, index}.
   function automatic logic [3:0] arbitrate(input logic [5:0] elig,
                                            input logic [2:0] ptr);
      logic       found;
      logic [2:0] win;
      logic [2:0] idx;
      found = 1'b0;
      win   = 3'd0;
      idx   = ptr;
      for (int k = 0; k < 6; k++) begin
         if (!found && elig[idx]) begin
            found = 1'b1;
            win   = idx;
         end
         idx = wrap_inc(idx);
      end
      return {found, win};
   endfunction

   // Unpack per-source fields and decide which sources carry master 1's tag.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < 6; i++) begin
         eligible[i] = bus.BVALID_S[i] && (bus.BID_S[8*i+6 +: 2] == 2'b10);
         bid_arr[i]  = bus.BID_S[8*i +: 4];
         resp_arr[i] = bus.BRESP_S[2*i +: 2];
      end
   end

   // Completed transfer this cycle, and which source's counter it retires.
   always_comb begin
      handshake = (state == GRANT) && bus.BVALID_S[g] && bus.BREADY_M;
      dec_vec   = '0;
      for (int i = 0; i < 6; i++) begin
         dec_vec[i] = handshake && (g == 3'(i));
      end
   end

   // Two arbitrations: one from P while idle, one excluding the current
   // winner (starting just after it) for back-to-back regrant.
   always_comb begin
      eligible_hs    = eligible;
      eligible_hs[g] = 1'b0;
      {idle_found, idle_win} = arbitrate(eligible, p);
      {hs_found, hs_win}     = arbitrate(eligible_hs, wrap_inc(g));
   end

   // State, grant index and round-robin pointer registers.
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state <= IDLE;
         g     <= 3'd0;
         p     <= 3'd0;
      end else begin
         state <= state_next;
         g     <= g_next;
         p     <= p_next;
      end
   end

   // Next-state logic and grant-muxed outputs; the grant only moves on a
   // handshake, so a source dropping BVALID just holds the lock.
   always_comb begin
      state_next = state;
      g_next     = g;
      p_next     = p;
      ready_vec  = '0;
      bus.BVALID_M = 1'b0;
      bus.BID_M    = 4'd0;
      bus.BRESP_M  = 2'b00;
      case (state)
         IDLE: begin
            if (idle_found) begin
               state_next = GRANT;
               g_next     = idle_win;
            end
         end
         GRANT: begin
            bus.BVALID_M = bus.BVALID_S[g];
            bus.BID_M    = bid_arr[g];
            bus.BRESP_M  = (g == 3'd5) ? 2'b11 : resp_arr[g];
            ready_vec[g] = bus.BREADY_M;
            if (handshake) begin
               p_next = wrap_inc(g);
               if (hs_found) begin
                  g_next = hs_win;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Outstanding-write counters (saturating) and the unexpected-response flag.
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         for (int i = 0; i < 6; i++) begin
            cnt[i] <= 3'd0;
         end
         resp_err <= 1'b0;
      end else begin
         for (int i = 0; i < 6; i++) begin
            case ({bus.AW_DONE[i], dec_vec[i]})
               2'b10:   if (cnt[i] != 3'd7) cnt[i] <= cnt[i] + 3'd1;
               2'b01:   if (cnt[i] != 3'd0) cnt[i] <= cnt[i] - 3'd1;
               default: cnt[i] <= cnt[i];
            endcase
         end
         resp_err <= handshake && (cnt[g] == 3'd0) && !bus.AW_DONE[g];
      end
   end

   assign bus.BREADY_S = ready_vec;
   assign bus.BUSY     = (state == GRANT);
   assign bus.RESP_ERR = resp_err;

endmodule
